// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : Iterative multiply/divide sequencer owning the HI/LO register
//            pair. Runs a one-bit-per-cycle shift-add multiply or restoring
//            divide on operand magnitudes, then applies sign correction in a
//            single FIX cycle before committing HI/LO.
// Ports    : clk        rising-edge clock
//            reset      asynchronous reset, active low
//            req_valid  EX stage presents a HI/LO-class instruction
//            req_ready  controller idle, can accept this cycle
//            Funct      instruction funct field
//            A, B       rs / rt operands
//            flush      squash the in-flight operation
//            done       one-cycle pulse, hi/lo hold the new result
//            busy       sequencer not idle
//            hi, lo     HI / LO registers
// Options  : MULDIV_FAST_MUL_EN - single-cycle multiplier, mult/multu skip
//            the iterative phase (IDLE -> FIX -> DONE). Divide unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic             done,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int             CW      = $clog2(ITER) + 1;
   localparam logic [CW-1:0]  c_LAST  = CW'(ITER - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_CALC = 2'd1;
   localparam logic [1:0] c_FIX  = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   localparam logic [5:0] c_F_MULT  = 6'b011000;
   localparam logic [5:0] c_F_MULTU = 6'b011001;
   localparam logic [5:0] c_F_DIV   = 6'b011010;
   localparam logic [5:0] c_F_DIVU  = 6'b011011;
   localparam logic [5:0] c_F_MTHI  = 6'b010001;
   localparam logic [5:0] c_F_MTLO  = 6'b010011;

   logic [1:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   // Multiply: r_acc is the product register {partial_hi, multiplier}.
   // Divide  : r_acc is {remainder, dividend-shifting-into-quotient}.
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_op;       // multiplicand or divisor magnitude
   logic               r_is_div;
   logic               r_neg;      // operand signs differ (signed ops only)
   logic               r_rem_neg;  // signed dividend was negative
   logic               r_bzero;    // divisor was zero

   logic               w_accept;
   logic               w_sign;
   logic               w_is_mul;
   logic               w_is_div;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_rem_next;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quot_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign req_ready = (r_state == c_IDLE);
   assign busy      = (r_state != c_IDLE);
   assign done      = (r_state == c_DONE);
   assign hi        = r_hi;
   assign lo        = r_lo;

   assign w_accept  = req_valid && req_ready && !flush;
   // Signed variants have Funct[0]==0.
   assign w_sign    = ~Funct[0];
   assign w_is_mul  = (Funct == c_F_MULT) || (Funct == c_F_MULTU);
   assign w_is_div  = (Funct == c_F_DIV)  || (Funct == c_F_DIVU);
   assign w_a_mag   = (w_sign && A[WIDTH-1]) ? (~A + 1'b1) : A;
   assign w_b_mag   = (w_sign && B[WIDTH-1]) ? (~B + 1'b1) : B;

   // Shift-add step: conditionally add multiplicand into the upper half,
   // then shift the whole product right with the carry entering at the top.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_op} : {(WIDTH+1){1'b0}});
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Restoring step: bring the next dividend bit into the remainder; keep
   // the difference only when it does not go negative.
   assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_ge       = (w_shift >= {1'b0, r_op});
   assign w_rem_next = w_ge ? WIDTH'(w_shift - {1'b0, r_op}) : w_shift[WIDTH-1:0];
   assign w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_ge};

   // With a zero divisor the algorithm yields quotient all-ones and
   // remainder |A|; skipping the quotient negation and restoring the
   // dividend sign on the remainder gives lo=all-ones, hi=A.
   assign w_prod_fix = r_neg ? (~r_acc + 1'b1) : r_acc;
   assign w_quot_fix = (r_neg && !r_bzero) ? (~r_acc[WIDTH-1:0] + 1'b1)
                                           : r_acc[WIDTH-1:0];
   assign w_rem_fix  = r_rem_neg ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                                 : r_acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] w_fast_prod;
   assign w_fast_prod = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= c_IDLE;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_acc     <= '0;
         r_op      <= '0;
         r_is_div  <= 1'b0;
         r_neg     <= 1'b0;
         r_rem_neg <= 1'b0;
         r_bzero   <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  if (Funct == c_F_MTHI) begin
                     r_hi <= A;
                  end else if (Funct == c_F_MTLO) begin
                     r_lo <= A;
                  end else if (w_is_div || w_is_mul) begin
                     r_is_div  <= w_is_div;
                     r_neg     <= w_sign && (A[WIDTH-1] ^ B[WIDTH-1]);
                     r_rem_neg <= w_sign && A[WIDTH-1];
                     r_bzero   <= (B == '0);
                     r_cnt     <= '0;
                     if (w_is_div) begin
                        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_op    <= w_b_mag;
                        r_state <= c_CALC;
                     end else begin
`ifdef MULDIV_FAST_MUL_EN
                        r_acc   <= w_fast_prod;
                        r_state <= c_FIX;
`else
                        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                        r_op    <= w_a_mag;
                        r_state <= c_CALC;
`endif
                     end
                  end
               end
            end
            c_CALC: begin
               if (flush) begin
                  r_state <= c_IDLE;
               end else begin
                  r_acc <= r_is_div ? w_div_next : w_mul_next;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == c_LAST) begin
                     r_state <= c_FIX;
                  end
               end
            end
            c_FIX: begin
               if (flush) begin
                  r_state <= c_IDLE;
               end else begin
                  if (r_is_div) begin
                     r_hi <= w_rem_fix;
                     r_lo <= w_quot_fix;
                  end else begin
                     r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod_fix[WIDTH-1:0];
                  end
                  r_state <= c_DONE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo from the EX stage over a valid/ready handshake and runs a 32-step shift-add multiply or restoring divide.
- Signals completion and holds off the pipeline (via ready) while busy; mfhi/mflo read the hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, WIDTH, number of calculation cycles. Must equal WIDTH; exists only to size the counter, $clog2(ITER)+1 bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- req_valid  in  1  EX stage presents a HI/LO-class instruction.
- req_ready  out  1  controller can accept this cycle.
- Funct  in  6  instruction funct field.
- A  in  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo source).
- B  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  cancel the in-flight operation (branch/exception squash).
- done  out  1  one-cycle pulse; hi/lo hold the new result.
- busy  out  1  state != IDLE.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0, internal accumulators=0. req_ready=1 once reset is released.
- Accept condition: req_valid && req_ready && !flush. req_ready = (state==IDLE).
- Funct decode:
  - 011000 mult (signed), 011001 multu, 011010 div (signed), 011011 divu.
  - 010001 mthi, 010011 mtlo.
  - Any other Funct is accepted and ignored; no state change, no done.
- Signedness: Sign = ~Funct[0], matching the existing ALU control convention.
- mthi/mtlo: write A into hi or lo at the accept edge. State stays IDLE, no done pulse, result visible the next cycle.
- States: IDLE -> CALC (ITER cycles) -> FIX (1 cycle) -> DONE (1 cycle) -> IDLE.
  - IDLE->CALC on an accepted mult/div. Operand magnitudes are latched (abs value when Sign=1), the sign flags are stored, and counter=0.
  - CALC:
    - Multiply: one shift-add step per cycle on a 2*WIDTH product register.
    - Divide: one restoring step per cycle; shift the remainder left, subtract the divisor, keep the result if non-negative, set the quotient bit.
    - counter increments each cycle; leave CALC when counter==ITER-1.
  - FIX sign correction:
    - mult: negate the 2*WIDTH product if the operand signs differ.
    - div: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
    - hi/lo are written at the FIX->DONE edge. mult: hi=product[2W-1:W], lo=product[W-1:0]. div: hi=remainder, lo=quotient.
  - DONE: done=1 for exactly this cycle; the next edge returns to IDLE.
- Latency: accept at edge E0; CALC spans cycles 1..32; FIX is cycle 33; done=1 and new hi/lo are visible in cycle 34; req_ready=1 in cycle 35.
- Divide by zero (B==0, signed or unsigned): normal latency, lo=all ones, hi=A (original, unsigned-interpreted value), done pulses.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This is the natural result of the algorithm; no trap.
- Flush:
  - In CALC or FIX: next state is IDLE, hi/lo unchanged, no done.
  - In DONE: no effect, since the result is already committed.
  - In IDLE: blocks acceptance that cycle.
- hi/lo change only on an mthi/mtlo accept or the FIX->DONE edge.
- Reset mid-operation: immediate return to the reset values above; the partial result is lost.

Optional Feature:
- MULDIV_FAST_MUL_EN
  - Defined: mult/multu compute the full product combinationally with a single-cycle multiplier at accept. Path is IDLE -> FIX -> DONE, so done appears in cycle 2 after accept. Divide is unchanged.
  - Undefined: iterative multiply as specified above. The CALC path is always present for divide.

Test Plan:
- mult A=0xFFFFFFFD (-3), B=5 -> done in cycle 34 (cycle 2 with MULDIV_FAST_MUL_EN); hi=0xFFFFFFFF, lo=0xFFFFFFF1; req_ready low cycles 1..34.
- multu A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu of the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- divu A=100, B=0 -> hi=0x00000064, lo=0xFFFFFFFF, done pulses at normal latency.
- mthi A=0x1234 then mtlo A=0x5678 on back-to-back cycles -> both accepted (req_ready stays 1), hi=0x1234, lo=0x5678, done never asserted.
- div started, flush in cycle 10 -> state IDLE in cycle 11, no done, hi/lo keep prior values; reset pulsed low mid-CALC -> hi=lo=0 immediately.
